// File: rtl/can_wb_pkg.sv
// Shared definitions for the CAN Wishbone slave front-end.
// Optional read pipeline stage is selected by the CAN_RD_PIPE_EN macro.
package can_wb_pkg;

   localparam int unsigned CanWbAw = 8;
   localparam int unsigned CanWbDw = 8;

`ifdef CAN_RD_PIPE_EN
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StAccess = 3'd1,
      StRdWait = 3'd2,
      StTerm   = 3'd3,
      StHold   = 3'd4
   } can_wb_state_e;
`else
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StAccess = 3'd1,
      StTerm   = 3'd3,
      StHold   = 3'd4
   } can_wb_state_e;
`endif

endpackage

// File: rtl/can_wb_slave.sv
// Wishbone classic slave front-end for the CAN register bank.
// Turns each bus cycle into one register strobe and one ack/err pulse.
// Define CAN_RD_PIPE_EN to add a wait state for banks with registered read data.
module can_wb_slave
   import can_wb_pkg::*;
#(
   parameter int unsigned AW       = CanWbAw,
   parameter int unsigned DW       = CanWbDw,
   parameter int unsigned ADDR_MAX = 31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          reg_cs_o,
   output logic          reg_we_o,
   output logic [AW-1:0] reg_addr_o,
   output logic [DW-1:0] reg_wdata_o,
   input  logic [DW-1:0] reg_rdata_i
);

   localparam logic [AW-1:0] AddrMax = AW'(ADDR_MAX);

   can_wb_state_e state_q, state_d;
   logic          is_wr_q, is_wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          cs_q, cs_d;
   logic          we_q, we_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;

   // Next-state and next-output decode; strobes default low so each lasts one cycle.
   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cs_d    = 1'b0;
      we_d    = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (wb_cyc_i && wb_stb_i) begin
               addr_d  = wb_adr_i;
               wdata_d = wb_dat_i;
               is_wr_d = wb_we_i;
               if (wb_adr_i <= AddrMax) begin
                  state_d = StAccess;
                  cs_d    = 1'b1;
                  we_d    = wb_we_i;
               end else begin
                  // Unimplemented address: terminate with err, never touch the bank.
                  state_d = StTerm;
                  err_d   = 1'b1;
               end
            end
         end
         StAccess: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else if (is_wr_q) begin
               ack_d   = 1'b1;
               state_d = StTerm;
            end else begin
`ifdef CAN_RD_PIPE_EN
               state_d = StRdWait;
`else
               // Capture before any clear-on-read effect lands at this same edge.
               rdata_d = reg_rdata_i;
               ack_d   = 1'b1;
               state_d = StTerm;
`endif
            end
         end
`ifdef CAN_RD_PIPE_EN
         StRdWait: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else begin
               rdata_d = reg_rdata_i;
               ack_d   = 1'b1;
               state_d = StTerm;
            end
         end
`endif
         StTerm: begin
            if (wb_cyc_i && wb_stb_i) state_d = StHold;
            else                      state_d = StIdle;
         end
         StHold: begin
            // Held strobe must not start a second access.
            if (!wb_cyc_i || !wb_stb_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; asynchronous reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cs_q    <= cs_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign wb_dat_o    = rdata_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign reg_cs_o    = cs_q;
   assign reg_we_o    = we_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_can_wb_slave.sv
// Directed self-checking bench for can_wb_slave with a small register bank model.
module tb_can_wb_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       wb_cyc, wb_stb, wb_we;
   logic [7:0] wb_adr, wb_dat_w, wb_dat_r;
   logic       wb_ack, wb_err;
   logic       reg_cs, reg_we;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;

   logic [7:0] mem [32];

   int checks = 0;
   int errors = 0;
   int cs_cnt, ack_cnt, err_cnt;

   can_wb_slave #(
      .AW       (8),
      .DW       (8),
      .ADDR_MAX (31)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_cyc_i    (wb_cyc),
      .wb_stb_i    (wb_stb),
      .wb_we_i     (wb_we),
      .wb_adr_i    (wb_adr),
      .wb_dat_i    (wb_dat_w),
      .wb_dat_o    (wb_dat_r),
      .wb_ack_o    (wb_ack),
      .wb_err_o    (wb_err),
      .reg_cs_o    (reg_cs),
      .reg_we_o    (reg_we),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_rdata_i (reg_rdata)
   );

   always #5 clk = ~clk;

   // Register bank model: combinational read, write on the strobe.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
         mem[1] <= 8'h3E;
         mem[3] <= 8'h5C;
      end else if (reg_cs && reg_we) begin
         mem[reg_addr[4:0]] <= reg_wdata;
      end
   end
   assign reg_rdata = mem[reg_addr[4:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cs_cnt  += int'(reg_cs);
      ack_cnt += int'(wb_ack);
      err_cnt += int'(wb_err);
   endtask

   task automatic req(input logic we, input logic [7:0] adr, input logic [7:0] dat);
      wb_cyc   = 1'b1;
      wb_stb   = 1'b1;
      wb_we    = we;
      wb_adr   = adr;
      wb_dat_w = dat;
   endtask

   task automatic idle_bus();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_bus();
      wb_adr   = 8'h00;
      wb_dat_w = 8'h00;
      cs_cnt = 0; ack_cnt = 0; err_cnt = 0;
      #12;
      check("rst_ack", wb_ack, 0);
      check("rst_err", wb_err, 0);
      check("rst_cs", reg_cs, 0);
      check("rst_we", reg_we, 0);
      check("rst_addr", reg_addr, 0);
      check("rst_wdata", reg_wdata, 0);
      check("rst_dat", wb_dat_r, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Write 0xA5 to 0x04
      req(1'b1, 8'h04, 8'hA5);
      tick();
      check("wr_cs", reg_cs, 1);
      check("wr_we", reg_we, 1);
      check("wr_addr", reg_addr, 8'h04);
      check("wr_wdata", reg_wdata, 8'hA5);
      check("wr_ack_early", wb_ack, 0);
      tick();
      check("wr_cs_drop", reg_cs, 0);
      check("wr_we_drop", reg_we, 0);
      check("wr_ack", wb_ack, 1);
      check("wr_dat_unchanged", wb_dat_r, 0);
      idle_bus();
      tick();
      check("wr_ack_one", wb_ack, 0);
      check("wr_addr_hold", reg_addr, 8'h04);
      check("wr_wdata_hold", reg_wdata, 8'hA5);

      // Read 0x03 -> 0x5C
      req(1'b0, 8'h03, 8'h00);
      tick();
      check("rd_cs", reg_cs, 1);
      check("rd_we", reg_we, 0);
      check("rd_addr", reg_addr, 8'h03);
      tick();
      check("rd_cs_drop", reg_cs, 0);
`ifdef CAN_RD_PIPE_EN
      check("rd_ack_wait", wb_ack, 0);
      tick();
`endif
      check("rd_ack", wb_ack, 1);
      check("rd_dat", wb_dat_r, 8'h5C);
      idle_bus();
      tick();
      check("rd_ack_one", wb_ack, 0);

      // Read back the earlier write
      req(1'b0, 8'h04, 8'h00);
      tick();
      tick();
`ifdef CAN_RD_PIPE_EN
      tick();
`endif
      check("rb_ack", wb_ack, 1);
      check("rb_dat", wb_dat_r, 8'hA5);
      idle_bus();
      tick();

      // Held strobe: one access, one ack
      cs_cnt = 0; ack_cnt = 0; err_cnt = 0;
      req(1'b0, 8'h03, 8'h00);
`ifdef CAN_RD_PIPE_EN
      for (int i = 0; i < 9; i++) tick();
`else
      for (int i = 0; i < 8; i++) tick();
`endif
      check("hold_cs_cnt", cs_cnt, 1);
      check("hold_ack_cnt", ack_cnt, 1);
      wb_stb = 1'b0;
      tick();
      check("hold_release_cs", reg_cs, 0);
      req(1'b1, 8'h05, 8'h77);
      tick();
      check("hold_next_cs", reg_cs, 1);
      check("hold_next_addr", reg_addr, 8'h05);
      tick();
      check("hold_next_ack", wb_ack, 1);
      idle_bus();
      tick();

      // Out-of-range address 0x40
      cs_cnt = 0; ack_cnt = 0; err_cnt = 0;
      req(1'b0, 8'h40, 8'h00);
      tick();
      check("err_err", wb_err, 1);
      check("err_cs", reg_cs, 0);
      idle_bus();
      tick();
      tick();
      check("err_one", wb_err, 0);
      check("err_cs_cnt", cs_cnt, 0);
      check("err_ack_cnt", ack_cnt, 0);
      check("err_err_cnt", err_cnt, 1);

      // Address boundary: 0x1F accepted, 0x20 errored
      req(1'b0, 8'h1F, 8'h00);
      tick();
      check("bnd31_cs", reg_cs, 1);
      check("bnd31_err", wb_err, 0);
      idle_bus();
      tick();
      tick();
      req(1'b0, 8'h20, 8'h00);
      tick();
      check("bnd32_cs", reg_cs, 0);
      check("bnd32_err", wb_err, 1);
      idle_bus();
      tick();
      tick();

      // Abort in ACCESS
      cs_cnt = 0; ack_cnt = 0;
      req(1'b1, 8'h06, 8'h11);
      tick();
      check("abt_cs", reg_cs, 1);
      idle_bus();
      tick();
      tick();
      tick();
      check("abt_ack_cnt", ack_cnt, 0);
      req(1'b1, 8'h07, 8'h22);
      tick();
      check("abt_next_cs", reg_cs, 1);
      check("abt_next_addr", reg_addr, 8'h07);
      check("abt_next_wdata", reg_wdata, 8'h22);
      tick();
      check("abt_next_ack", wb_ack, 1);
      idle_bus();
      tick();

      // Reset during TERM
      req(1'b0, 8'h01, 8'h00);
      tick();
      tick();
`ifdef CAN_RD_PIPE_EN
      tick();
`endif
      check("rst_term_ack_pre", wb_ack, 1);
      check("rst_term_dat_pre", wb_dat_r, 8'h3E);
      rst = 1'b1;
      #1;
      check("rst_term_ack", wb_ack, 0);
      check("rst_term_cs", reg_cs, 0);
      check("rst_term_dat", wb_dat_r, 0);
      idle_bus();
      @(negedge clk);
      rst = 1'b0;
      tick();
      req(1'b0, 8'h01, 8'h00);
      tick();
      check("post_rst_cs", reg_cs, 1);
      tick();
`ifdef CAN_RD_PIPE_EN
      tick();
`endif
      check("post_rst_ack", wb_ack, 1);
      check("post_rst_dat", wb_dat_r, 8'h3E);
      idle_bus();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
